// File: rtl/dualmem_arb.sv
// dualmem_arb: two-requester round-robin arbiter in front of a single-port
// 512 x 64 memory with byte enables. Read data returns one cycle after grant.
// Optional zero-fill sequencer after reset: define DUALMEM_ARB_INIT_EN.
module dualmem_arb (
   input  logic        clk,
   input  logic        rst,
   // requester 0
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [8:0]  req0_addr,
   input  logic [7:0]  req0_we,
   input  logic [63:0] req0_wdata,
   output logic        rsp0_valid,
   output logic [63:0] rsp0_rdata,
   // requester 1
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [8:0]  req1_addr,
   input  logic [7:0]  req1_we,
   input  logic [63:0] req1_wdata,
   output logic        rsp1_valid,
   output logic [63:0] rsp1_rdata,
   // memory port
   output logic        mem_en,
   output logic [8:0]  mem_addr,
   output logic [7:0]  mem_we,
   output logic [63:0] mem_din,
   input  logic [63:0] mem_dout,
   output logic        init_done
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

`ifdef DUALMEM_ARB_INIT_EN
   localparam state_e ResetState = StInit;
   logic [8:0] fill_cnt_q;
`else
   localparam state_e ResetState = StRun;
`endif

   state_e state_q;
   logic   ptr_q;   // 0: requester 0 wins a tie, 1: requester 1 wins
   logic   rd0_q;   // read granted to requester 0 last cycle
   logic   rd1_q;   // read granted to requester 1 last cycle
   logic   run;
   logic   gnt0;
   logic   gnt1;

   // Accept traffic only in RUN and never while reset is held.
   always_comb begin
      run  = (state_q == StRun) && !rst;
      gnt0 = run && req0_valid && (!req1_valid || !ptr_q);
      gnt1 = run && req1_valid && (!req0_valid || ptr_q);
   end

   assign init_done  = run;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Memory port mux: granted requester, else fill sequencer, else idle.
   always_comb begin
      mem_en   = 1'b0;
      mem_addr = '0;
      mem_we   = '0;
      mem_din  = '0;
      if (gnt0) begin
         mem_en   = 1'b1;
         mem_addr = req0_addr;
         mem_we   = req0_we;
         mem_din  = req0_wdata;
      end else if (gnt1) begin
         mem_en   = 1'b1;
         mem_addr = req1_addr;
         mem_we   = req1_we;
         mem_din  = req1_wdata;
      end
`ifdef DUALMEM_ARB_INIT_EN
      else if (!rst && (state_q == StInit)) begin
         mem_en   = 1'b1;
         mem_addr = fill_cnt_q;
         mem_we   = 8'hFF;
         mem_din  = '0;
      end
`endif
   end

   // Responses track the memory's one-cycle read latency; reset squashes them.
   always_comb begin
      rsp0_valid = rd0_q && !rst;
      rsp1_valid = rd1_q && !rst;
      rsp0_rdata = mem_dout;
      rsp1_rdata = mem_dout;
   end

   // Control FSM, priority pointer and read-pending flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ResetState;
         ptr_q      <= 1'b0;
         rd0_q      <= 1'b0;
         rd1_q      <= 1'b0;
`ifdef DUALMEM_ARB_INIT_EN
         fill_cnt_q <= '0;
`endif
      end else begin
         unique case (state_q)
            StInit: begin
`ifdef DUALMEM_ARB_INIT_EN
               fill_cnt_q <= fill_cnt_q + 9'd1;
               if (fill_cnt_q == 9'd511) state_q <= StRun;
`else
               state_q <= StRun;
`endif
            end
            StRun: state_q <= StRun;
            default: state_q <= ResetState;
         endcase
         // Point at the loser so it wins the next tie.
         if (gnt0)      ptr_q <= 1'b1;
         else if (gnt1) ptr_q <= 1'b0;
         rd0_q <= gnt0 && (req0_we == 8'h00);
         rd1_q <= gnt1 && (req1_we == 8'h00);
      end
   end

endmodule

// File: tb/tb_dualmem_arb.sv
// Directed self-checking bench for dualmem_arb.
module tb_dualmem_arb;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [8:0]  req0_addr, req1_addr;
   logic [7:0]  req0_we, req1_we;
   logic [63:0] req0_wdata, req1_wdata;
   logic        rsp0_valid, rsp1_valid;
   logic [63:0] rsp0_rdata, rsp1_rdata;
   logic        mem_en;
   logic [8:0]  mem_addr;
   logic [7:0]  mem_we;
   logic [63:0] mem_din;
   logic [63:0] mem_dout;
   logic        init_done;

   int n_tests = 0;
   int n_fail  = 0;

   dualmem_arb dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_we    (req0_we),
      .req0_wdata (req0_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_we    (req1_we),
      .req1_wdata (req1_wdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .mem_en     (mem_en),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .init_done  (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        v0;
      logic [8:0]  a0;
      logic [7:0]  we0;
      logic [63:0] d0;
      logic        v1;
      logic [8:0]  a1;
      logic [7:0]  we1;
      logic [63:0] d1;
      logic [63:0] dout;
      logic        r0;
      logic        r1;
      logic        en;
      logic [8:0]  addr;
      logic [7:0]  we;
      logic [63:0] din;
      logic        rsp0;
      logic        rsp1;
      logic [63:0] rdata;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Drive one cycle of requests at the falling edge; outputs settle 2 ns later.
   task automatic step(input logic v0, input logic [8:0] a0, input logic [7:0] we0,
                       input logic [63:0] d0, input logic v1, input logic [8:0] a1,
                       input logic [7:0] we1, input logic [63:0] d1, input logic [63:0] dout);
      @(negedge clk);
      req0_valid = v0; req0_addr = a0; req0_we = we0; req0_wdata = d0;
      req1_valid = v1; req1_addr = a1; req1_we = we1; req1_wdata = d1;
      mem_dout   = dout;
      #2;
   endtask

   task automatic idle();
      step(1'b0, 9'd0, 8'd0, 64'd0, 1'b0, 9'd0, 8'd0, 64'd0, 64'd0);
   endtask

   // Drop reset; with the fill sequencer, check every fill write and no grants.
   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
`ifdef DUALMEM_ARB_INIT_EN
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #2;
      for (int i = 0; i < 512; i++) begin
         chk("fill_en", {63'd0, mem_en}, 64'd1);
         chk("fill_addr", {55'd0, mem_addr}, i);
         chk("fill_we", {56'd0, mem_we}, 64'hFF);
         chk("fill_din", mem_din, 64'd0);
         chk("fill_rdy", {62'd0, req0_ready, req1_ready}, 64'd0);
         chk("fill_done", {63'd0, init_done}, 64'd0);
         @(negedge clk);
         if (i == 511) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end
      #2;
`else
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #2;
`endif
      chk("init_done_after_rst", {63'd0, init_done}, 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #2;
      chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
      chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
      chk("rst_mem_we", {56'd0, mem_we}, 64'd0);
      chk("rst_init_done", {63'd0, init_done}, 64'd0);
      @(negedge clk);
      #2;
      chk("rst_rsp", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
      release_reset();
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_addr = '0; req0_we = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_we = '0; req1_wdata = '0;
      mem_dout = '0;

      //           v0  a0      we0    d0                      v1  a1      we1    d1
      //           dout                    r0  r1  en  addr    we     din
      //           rsp0 rsp1 rdata
      vecs[0]  = '{1, 9'h005, 8'h00, 64'h5555, 0, 9'h000, 8'h00, 64'h0,
                   64'h0, 1, 0, 1, 9'h005, 8'h00, 64'h5555, 0, 0, 64'h0};
      vecs[1]  = '{0, 9'h000, 8'h00, 64'h0, 0, 9'h000, 8'h00, 64'h0,
                   64'hDEADBEEF_00000005, 0, 0, 0, 9'h000, 8'h00, 64'h0,
                   1, 0, 64'hDEADBEEF_00000005};
      vecs[2]  = '{1, 9'h010, 8'hFF, 64'hAAAABBBB_CCCCDDDD, 1, 9'h020, 8'h00, 64'h0,
                   64'h0, 0, 1, 1, 9'h020, 8'h00, 64'h0, 0, 0, 64'h0};
      vecs[3]  = '{1, 9'h010, 8'hFF, 64'hAAAABBBB_CCCCDDDD, 1, 9'h020, 8'h00, 64'h0,
                   64'h1234, 1, 0, 1, 9'h010, 8'hFF, 64'hAAAABBBB_CCCCDDDD, 0, 1, 64'h1234};
      vecs[4]  = '{0, 9'h000, 8'h00, 64'h0, 1, 9'h1FF, 8'h0F, 64'h11223344_55667788,
                   64'h0, 0, 1, 1, 9'h1FF, 8'h0F, 64'h11223344_55667788, 0, 0, 64'h0};
      vecs[5]  = '{0, 9'h000, 8'h00, 64'h0, 0, 9'h000, 8'h00, 64'h0,
                   64'h99, 0, 0, 0, 9'h000, 8'h00, 64'h0, 0, 0, 64'h0};
      vecs[6]  = '{0, 9'h000, 8'h00, 64'h0, 1, 9'h100, 8'h00, 64'h0,
                   64'h0, 0, 1, 1, 9'h100, 8'h00, 64'h0, 0, 0, 64'h0};
      vecs[7]  = '{1, 9'h101, 8'h00, 64'h0, 1, 9'h102, 8'h00, 64'h0,
                   64'hCAFE, 1, 0, 1, 9'h101, 8'h00, 64'h0, 0, 1, 64'hCAFE};
      vecs[8]  = '{1, 9'h103, 8'h00, 64'h0, 1, 9'h104, 8'h00, 64'h0,
                   64'hBEEF, 0, 1, 1, 9'h104, 8'h00, 64'h0, 1, 0, 64'hBEEF};
      vecs[9]  = '{0, 9'h000, 8'h00, 64'h0, 0, 9'h000, 8'h00, 64'h0,
                   64'h77, 0, 0, 0, 9'h000, 8'h00, 64'h0, 0, 1, 64'h77};
      vecs[10] = '{0, 9'h000, 8'h00, 64'h0, 0, 9'h000, 8'h00, 64'h0,
                   64'h88, 0, 0, 0, 9'h000, 8'h00, 64'h0, 0, 0, 64'h0};

      repeat (2) @(negedge clk);
      do_reset();

      // Table-driven vectors, starting with the pointer at requester 0.
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].v0, vecs[i].a0, vecs[i].we0, vecs[i].d0,
              vecs[i].v1, vecs[i].a1, vecs[i].we1, vecs[i].d1, vecs[i].dout);
         chk($sformatf("v%0d_ready0", i), {63'd0, req0_ready}, {63'd0, vecs[i].r0});
         chk($sformatf("v%0d_ready1", i), {63'd0, req1_ready}, {63'd0, vecs[i].r1});
         chk($sformatf("v%0d_mem_en", i), {63'd0, mem_en}, {63'd0, vecs[i].en});
         chk($sformatf("v%0d_mem_we", i), {56'd0, mem_we}, {56'd0, vecs[i].we});
         chk($sformatf("v%0d_rsp0", i), {63'd0, rsp0_valid}, {63'd0, vecs[i].rsp0});
         chk($sformatf("v%0d_rsp1", i), {63'd0, rsp1_valid}, {63'd0, vecs[i].rsp1});
         if (vecs[i].en) begin
            chk($sformatf("v%0d_mem_addr", i), {55'd0, mem_addr}, {55'd0, vecs[i].addr});
            chk($sformatf("v%0d_mem_din", i), mem_din, vecs[i].din);
         end
         if (vecs[i].rsp0) chk($sformatf("v%0d_rdata0", i), rsp0_rdata, vecs[i].rdata);
         if (vecs[i].rsp1) chk($sformatf("v%0d_rdata1", i), rsp1_rdata, vecs[i].rdata);
      end

      // Contention straight after reset alternates 0,1,0,1.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 9'h030, 8'h00, 64'h0, 1'b1, 9'h031, 8'h00, 64'h0, 64'h0);
         chk($sformatf("rr%0d_ready0", i), {63'd0, req0_ready}, {63'd0, ((i % 2) == 0)});
         chk($sformatf("rr%0d_ready1", i), {63'd0, req1_ready}, {63'd0, ((i % 2) == 1)});
      end
      idle();

      // Read grant to req0 (pointer moves to 1), then reset in the next cycle.
      step(1'b1, 9'h040, 8'h00, 64'h0, 1'b0, 9'h000, 8'h00, 64'h0, 64'h0);
      chk("mid_grant0", {63'd0, req0_ready}, 64'd1);
      @(negedge clk);
      rst = 1'b1;
      req1_valid = 1'b1;
      mem_dout = 64'hFFFF;
      #2;
      chk("mid_rsp_squash", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
      chk("mid_rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
      chk("mid_rst_mem_en", {63'd0, mem_en}, 64'd0);
      release_reset();
      step(1'b1, 9'h041, 8'h00, 64'h0, 1'b1, 9'h042, 8'h00, 64'h0, 64'h0);
      chk("post_rst_ready0", {63'd0, req0_ready}, 64'd1);
      chk("post_rst_ready1", {63'd0, req1_ready}, 64'd0);
      chk("post_rst_rsp", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
      idle();

`ifdef DUALMEM_ARB_INIT_EN
      // Reset while the fill is at address 100 restarts it from 0.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2;
      for (int i = 0; i < 100; i++) begin
         chk("abort_fill_addr", {55'd0, mem_addr}, i);
         @(negedge clk);
         #2;
      end
      chk("abort_fill_addr100", {55'd0, mem_addr}, 64'd100);
      rst = 1'b1;
      #1;
      chk("abort_rst_mem_en", {63'd0, mem_en}, 64'd0);
      release_reset();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
